rtlola_event_player: RTL and testbench

//  Synthesizable, parametrised stimulus source for the generated monitor (topEntity).

---
 rtl/rtlola_player_pkg.sv | 34 +++
 rtl/rtlola_delay_timer.sv | 41 ++++
 rtl/rtlola_event_player.sv | 177 +++++++++++++++++
 tb/tb_rtlola_event_player.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rtlola_player_pkg.sv
// Shared types and record-layout helpers for the RTLola event player.
// A record is {delta, mask[N_IN-1:0], val[N_IN-1:0]}, with val lane 0 in the LSBs.
package rtlola_player_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    WAIT  = 3'd2,
    DELAY = 3'd3,
    ISSUE = 3'd4,
    TAIL  = 3'd5,
    DONE  = 3'd6
  } state_e;

  // Shortest issue-to-issue spacing the FETCH/WAIT round trip allows.
  localparam int MIN_GAP = 3;

  function automatic int val_lsb(input int data_w, input int lane);
    return lane * data_w;
  endfunction

  function automatic int mask_lsb(input int n_in, input int data_w);
    return n_in * data_w;
  endfunction

  function automatic int delta_lsb(input int n_in, input int data_w);
    return n_in * data_w + n_in;
  endfunction

  function automatic int rec_width(input int dt_w, input int n_in, input int data_w);
    return dt_w + n_in + n_in * data_w;
  endfunction

endpackage

// File: rtl/rtlola_delay_timer.sv
// Saturating cycle counter measuring the distance from the last reference point
// (start or issue). Flags are evaluated one cycle ahead, because the state change they trigger lands on the next cycle.
module rtlola_delay_timer #(
  parameter int DT_W = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            load,
  input  logic [DT_W-1:0] delta,
  output logic            due,
  output logic            late
);

  logic [DT_W-1:0] cnt_q, cnt_d;
  logic [DT_W:0]   ahead;

  always_comb begin
    cnt_d = cnt_q;
    if (en) begin
      if (load) begin
        cnt_d = {{(DT_W-1){1'b0}}, 1'b1};
      end else if (cnt_q != {DT_W{1'b1}}) begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign ahead = {1'b0, cnt_q} + {{DT_W{1'b0}}, 1'b1};
  assign due   = (ahead >= {1'b0, delta});
  assign late  = (ahead >  {1'b0, delta});

endmodule

// File: rtl/rtlola_event_player.sv
// Replays timestamped input events from a synchronous event memory into the
// monitor, honouring its ready signal, then signals done after a fixed tail.
module rtlola_event_player #(
  parameter int N_IN     = 2,
  parameter int DATA_W   = 64,
  parameter int DT_W     = 32,
  parameter int ADDR_W   = 8,
  parameter int TAIL_CYC = 40
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             en,
  input  logic                             start,
  output logic [ADDR_W-1:0]                ev_addr,
  output logic                             ev_rd,
  input  logic [DT_W+N_IN+N_IN*DATA_W-1:0] ev_rdata,
  input  logic                             mon_ready,
  output logic [N_IN*DATA_W-1:0]           in_data,
  output logic [N_IN-1:0]                  new_in,
  output logic                             busy,
  output logic                             done,
  output logic [ADDR_W:0]                  ev_count,
  output logic [DT_W-1:0]                  late_count
);

  import rtlola_player_pkg::*;

  localparam int REC_W     = rec_width(DT_W, N_IN, DATA_W);
  localparam int MASK_LSB  = mask_lsb(N_IN, DATA_W);
  localparam int DELTA_LSB = delta_lsb(N_IN, DATA_W);

  state_e                 state_q, state_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic [DT_W-1:0]        delta_q, delta_d;
  logic [N_IN-1:0]        mask_q, mask_d;
  logic [N_IN*DATA_W-1:0] val_q, val_d;
  logic [ADDR_W:0]        ev_count_q, ev_count_d;
  logic [DT_W-1:0]        late_count_q, late_count_d;

  logic [DT_W-1:0]        rd_delta;
  logic [N_IN-1:0]        rd_mask;
  logic [N_IN*DATA_W-1:0] rd_val;
  logic [N_IN*DATA_W-1:0] lane_data;

  logic                   tmr_load;
  logic [DT_W-1:0]        tmr_delta;
  logic                   tmr_due;
  logic                   tmr_late;
  logic                   late_inc;

  assign rd_delta = ev_rdata[DELTA_LSB +: DT_W];
  assign rd_mask  = ev_rdata[MASK_LSB +: N_IN];
  assign rd_val   = ev_rdata[N_IN*DATA_W-1:0];

  for (genvar gi = 0; gi < N_IN; gi++) begin : g_lane
    assign lane_data[val_lsb(DATA_W, gi) +: DATA_W] =
      mask_q[gi] ? val_q[val_lsb(DATA_W, gi) +: DATA_W] : {DATA_W{1'b0}};
  end

  rtlola_delay_timer #(
    .DT_W (DT_W)
  ) u_timer (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .load  (tmr_load),
    .delta (tmr_delta),
    .due   (tmr_due),
    .late  (tmr_late)
  );

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    delta_d      = delta_q;
    mask_d       = mask_q;
    val_d        = val_q;
    ev_count_d   = ev_count_q;
    late_count_d = late_count_q;
    tmr_load     = 1'b0;
    tmr_delta    = delta_q;
    late_inc     = 1'b0;
    ev_rd        = 1'b0;
    new_in       = '0;
    in_data      = '0;

    unique case (state_q)
      IDLE, DONE: begin
        if (en && start) begin
          state_d      = FETCH;
          addr_d       = '0;
          ev_count_d   = '0;
          late_count_d = '0;
          tmr_load     = 1'b1;
        end
      end
      FETCH: begin
        ev_rd = en;
        if (en) state_d = WAIT;
      end
      WAIT: begin
        // The record is still on the bus here, so judge it directly; an
        // already-due event skips DELAY to keep the MIN_GAP spacing.
        tmr_delta = rd_delta;
        if (en) begin
          delta_d = rd_delta;
          mask_d  = rd_mask;
          val_d   = rd_val;
          if (rd_mask == '0) begin
            state_d = TAIL;
          end else if (tmr_due && mon_ready) begin
            state_d  = ISSUE;
            late_inc = tmr_late;
          end else begin
            state_d = DELAY;
          end
        end
      end
      DELAY: begin
        if (en && tmr_due && mon_ready) begin
          state_d  = ISSUE;
          late_inc = tmr_late;
        end
      end
      ISSUE: begin
        in_data = lane_data;
        if (en) begin
          new_in   = mask_q;
          tmr_load = 1'b1;
          if (ev_count_q != {(ADDR_W+1){1'b1}}) ev_count_d = ev_count_q + 1'b1;
          if (addr_q == {ADDR_W{1'b1}}) begin
            state_d = TAIL;
          end else begin
            state_d = FETCH;
            addr_d  = addr_q + 1'b1;
          end
        end
      end
      TAIL: begin
        // Tail is timed from the last issue (or from start if nothing issued).
        tmr_delta = DT_W'(TAIL_CYC);
        if (en && tmr_due) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase

    if (late_inc && late_count_q != {DT_W{1'b1}}) late_count_d = late_count_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      delta_q      <= '0;
      mask_q       <= '0;
      val_q        <= '0;
      ev_count_q   <= '0;
      late_count_q <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      delta_q      <= delta_d;
      mask_q       <= mask_d;
      val_q        <= val_d;
      ev_count_q   <= ev_count_d;
      late_count_q <= late_count_d;
    end
  end

  assign ev_addr    = addr_q;
  assign busy       = (state_q == FETCH) || (state_q == WAIT) || (state_q == DELAY) ||
                      (state_q == ISSUE) || (state_q == TAIL);
  assign done       = (state_q == DONE);
  assign ev_count   = ev_count_q;
  assign late_count = late_count_q;

endmodule

// File: tb/tb_rtlola_event_player.sv
// Directed bench for rtlola_event_player: behavioural 1-cycle ROM, scheduled
// ready/enable windows, and one task per scenario with inline checks.
module tb_rtlola_event_player;
  import rtlola_player_pkg::*;

  localparam int N_IN     = 2;
  localparam int DATA_W   = 64;
  localparam int DT_W     = 32;
  localparam int ADDR_W   = 8;
  localparam int TAIL_CYC = 40;
  localparam int REC_W    = DT_W + N_IN + N_IN * DATA_W;

  logic                   clk = 1'b0;
  logic                   rst = 1'b0;
  logic                   en = 1'b1;
  logic                   start = 1'b0;
  logic                   mon_ready = 1'b1;
  logic [ADDR_W-1:0]      ev_addr;
  logic                   ev_rd;
  logic [REC_W-1:0]       ev_rdata = '0;
  logic [N_IN*DATA_W-1:0] in_data;
  logic [N_IN-1:0]        new_in;
  logic                   busy;
  logic                   done;
  logic [ADDR_W:0]        ev_count;
  logic [DT_W-1:0]        late_count;

  logic [REC_W-1:0] rom [0:255];
  int cyc = 0;
  int checks = 0;
  int failures = 0;
  int rdy_lo_a = -1, rdy_lo_b = -1;
  int en_lo_a = -1, en_lo_b = -1;
  int poke_cyc = -1;

  rtlola_event_player #(
    .N_IN(N_IN), .DATA_W(DATA_W), .DT_W(DT_W), .ADDR_W(ADDR_W), .TAIL_CYC(TAIL_CYC)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .start(start),
    .ev_addr(ev_addr), .ev_rd(ev_rd), .ev_rdata(ev_rdata), .mon_ready(mon_ready),
    .in_data(in_data), .new_in(new_in), .busy(busy), .done(done),
    .ev_count(ev_count), .late_count(late_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (ev_rd) ev_rdata <= rom[ev_addr];

  function automatic logic [REC_W-1:0] rec(input logic [31:0] delta, input logic [1:0] mask,
                                           input logic [63:0] v0, input logic [63:0] v1);
    return {delta, mask, v1, v0};
  endfunction

  task automatic step();
    @(posedge clk); #1;
    mon_ready = !(cyc >= rdy_lo_a && cyc <= rdy_lo_b);
    en        = !(cyc >= en_lo_a && cyc <= en_lo_b);
    start     = (cyc == poke_cyc);
  endtask

  task automatic clear_sched();
    rdy_lo_a = -1; rdy_lo_b = -1; en_lo_a = -1; en_lo_b = -1; poke_cyc = -1;
  endtask

  task automatic do_start(output int t0);
    @(posedge clk); #1;
    start = 1'b1;
    t0 = cyc;
    step();
  endtask

  task automatic wait_issue(input int budget, output int at, output logic [1:0] nin,
                            output logic [127:0] dat);
    at = -1; nin = '0; dat = '0;
    for (int i = 0; i < budget; i++) begin
      step();
      if (new_in != '0) begin
        at = cyc; nin = new_in; dat = in_data;
        break;
      end
    end
  endtask

  task automatic wait_done(input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      step();
      if (done) begin
        at = cyc;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, ev_rd, new_in, in_data, ev_addr, ev_count, late_count} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: busy=%0b done=%0b rd=%0b new_in=%b addr=%0d cnt=%0d late=%0d expected all 0",
               busy, done, ev_rd, new_in, ev_addr, ev_count, late_count);
    end
    rst = 1'b1;
    step();
  endtask

  task automatic test_two_events();
    int t0, at, dn;
    logic [1:0] nin;
    logic [127:0] dat;
    rom[0] = rec(1000, 2'b11, 64'd1, 64'd1);
    rom[1] = rec(1000, 2'b11, 64'd2, 64'd2);
    rom[2] = rec(0, 2'b00, 64'd0, 64'd0);
    do_start(t0);
    wait_issue(1200, at, nin, dat);
    checks++;
    if (at !== t0 + 1000 || nin !== 2'b11 || dat !== {64'd1, 64'd1}) begin
      failures++;
      $display("FAIL two_ev_first: at=%0d new_in=%b data=%h expected at=%0d new_in=11 data=1/1",
               at, nin, dat, t0 + 1000);
    end
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      failures++;
      $display("FAIL two_ev_busy: busy=%0b done=%0b expected 1/0", busy, done);
    end
    wait_issue(1200, at, nin, dat);
    checks++;
    if (at !== t0 + 2000 || nin !== 2'b11 || dat !== {64'd2, 64'd2}) begin
      failures++;
      $display("FAIL two_ev_second: at=%0d new_in=%b data=%h expected at=%0d new_in=11 data=2/2",
               at, nin, dat, t0 + 2000);
    end
    wait_done(100, dn);
    checks++;
    if (dn !== t0 + 2000 + TAIL_CYC) begin
      failures++;
      $display("FAIL two_ev_done_time: got %0d expected %0d", dn, t0 + 2000 + TAIL_CYC);
    end
    checks++;
    if (ev_count !== 9'd2 || late_count !== 32'd0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL two_ev_stats: ev_count=%0d late=%0d busy=%0b expected 2/0/0",
               ev_count, late_count, busy);
    end
    repeat (3) step();
    checks++;
    if (done !== 1'b1) begin
      failures++;
      $display("FAIL two_ev_done_held: done=%0b expected 1", done);
    end
  endtask

  task automatic test_masked_lane();
    int t0, at, dn;
    logic [1:0] nin;
    logic [127:0] dat;
    rom[0] = rec(700, 2'b01, 64'd5, 64'h77);
    rom[1] = rec(0, 2'b00, 64'd0, 64'd0);
    do_start(t0);
    checks++;
    if (ev_count !== 9'd0 || done !== 1'b0) begin
      failures++;
      $display("FAIL mask_restart: ev_count=%0d done=%0b expected 0/0", ev_count, done);
    end
    wait_issue(800, at, nin, dat);
    checks++;
    if (at !== t0 + 700 || nin !== 2'b01 || dat[63:0] !== 64'd5 || dat[127:64] !== 64'd0) begin
      failures++;
      $display("FAIL mask_issue: at=%0d new_in=%b data=%h expected at=%0d new_in=01 lane0=5 lane1=0",
               at, nin, dat, t0 + 700);
    end
    step();
    checks++;
    if (new_in !== 2'b00 || in_data !== '0) begin
      failures++;
      $display("FAIL mask_pulse_width: new_in=%b data=%h expected 0/0", new_in, in_data);
    end
    wait_done(100, dn);
  endtask

  task automatic test_back_to_back();
    int t0, at1, at2, dn;
    logic [1:0] nin;
    logic [127:0] dat;
    rom[0] = rec(10, 2'b10, 64'd0, 64'd7);
    rom[1] = rec(1, 2'b01, 64'd8, 64'd0);
    rom[2] = rec(0, 2'b00, 64'd0, 64'd0);
    do_start(t0);
    wait_issue(50, at1, nin, dat);
    checks++;
    if (at1 !== t0 + 10 || nin !== 2'b10 || dat[127:64] !== 64'd7) begin
      failures++;
      $display("FAIL b2b_first: at=%0d new_in=%b expected at=%0d new_in=10 lane1=7", at1, nin, t0 + 10);
    end
    wait_issue(50, at2, nin, dat);
    checks++;
    if (at2 - at1 !== MIN_GAP || nin !== 2'b01 || dat[63:0] !== 64'd8) begin
      failures++;
      $display("FAIL b2b_gap: gap=%0d new_in=%b expected gap=3 new_in=01 lane0=8", at2 - at1, nin);
    end
    checks++;
    if (late_count !== 32'd1) begin
      failures++;
      $display("FAIL b2b_late: late=%0d expected 1", late_count);
    end
    wait_done(100, dn);
    checks++;
    if (dn !== at2 + TAIL_CYC || ev_count !== 9'd2) begin
      failures++;
      $display("FAIL b2b_done: at=%0d ev_count=%0d expected at=%0d ev_count=2", dn, ev_count, at2 + TAIL_CYC);
    end
  endtask

  task automatic test_backpressure();
    int t0, at, dn;
    logic [1:0] nin;
    logic [127:0] dat;
    rom[0] = rec(50, 2'b11, 64'd3, 64'd4);
    rom[1] = rec(0, 2'b00, 64'd0, 64'd0);
    do_start(t0);
    rdy_lo_a = t0 + 49;
    rdy_lo_b = t0 + 58;
    wait_issue(100, at, nin, dat);
    checks++;
    if (at !== t0 + 60 || nin !== 2'b11 || dat !== {64'd4, 64'd3}) begin
      failures++;
      $display("FAIL bp_issue: at=%0d new_in=%b data=%h expected at=%0d new_in=11 data=4/3",
               at, nin, dat, t0 + 60);
    end
    checks++;
    if (late_count !== 32'd1) begin
      failures++;
      $display("FAIL bp_late: late=%0d expected 1", late_count);
    end
    clear_sched();
    wait_done(100, dn);
  endtask

  task automatic test_reset_mid_delay();
    int t0, at;
    logic [1:0] nin;
    logic [127:0] dat;
    rom[0] = rec(20, 2'b01, 64'd11, 64'd0);
    rom[1] = rec(200, 2'b10, 64'd0, 64'd22);
    rom[2] = rec(0, 2'b00, 64'd0, 64'd0);
    do_start(t0);
    wait_issue(50, at, nin, dat);
    repeat (30) step();
    checks++;
    if (ev_count !== 9'd1 || ev_addr !== 8'd1 || busy !== 1'b1) begin
      failures++;
      $display("FAIL rst_pre: ev_count=%0d addr=%0d busy=%0b expected 1/1/1", ev_count, ev_addr, busy);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({busy, done, ev_rd, new_in, in_data, ev_addr, ev_count, late_count} !== '0) begin
      failures++;
      $display("FAIL rst_async: busy=%0b done=%0b rd=%0b new_in=%b addr=%0d cnt=%0d expected all 0",
               busy, done, ev_rd, new_in, ev_addr, ev_count);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) step();
    do_start(t0);
    checks++;
    if (ev_rd !== 1'b1 || ev_addr !== 8'd0) begin
      failures++;
      $display("FAIL rst_refetch: rd=%0b addr=%0d expected 1/0", ev_rd, ev_addr);
    end
    wait_issue(50, at, nin, dat);
    checks++;
    if (at !== t0 + 20 || nin !== 2'b01 || dat[63:0] !== 64'd11) begin
      failures++;
      $display("FAIL rst_replay: at=%0d new_in=%b lane0=%0d expected at=%0d new_in=01 lane0=11",
               at, nin, dat[63:0], t0 + 20);
    end
    // Abandon the rest of this replay with another reset.
    #2 rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    step();
  endtask

  task automatic test_enable_freeze();
    int t0, at, dn;
    logic [1:0] nin;
    logic [127:0] dat;
    rom[0] = rec(100, 2'b10, 64'd0, 64'd9);
    rom[1] = rec(0, 2'b00, 64'd0, 64'd0);
    do_start(t0);
    en_lo_a  = t0 + 50;
    en_lo_b  = t0 + 54;
    poke_cyc = t0 + 30;
    wait_issue(200, at, nin, dat);
    checks++;
    if (at !== t0 + 105 || nin !== 2'b10 || dat[127:64] !== 64'd9) begin
      failures++;
      $display("FAIL en_issue: at=%0d new_in=%b expected at=%0d new_in=10 lane1=9", at, nin, t0 + 105);
    end
    clear_sched();
    wait_done(100, dn);
    checks++;
    if (dn !== at + TAIL_CYC || ev_count !== 9'd1 || late_count !== 32'd0) begin
      failures++;
      $display("FAIL en_done: at=%0d ev_count=%0d late=%0d expected at=%0d ev_count=1 late=0",
               dn, ev_count, late_count, at + TAIL_CYC);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = '0;
    test_reset();
    test_two_events();
    test_masked_lane();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_delay();
    test_enable_freeze();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
